pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller driving the 6-bit program counter of the single-cycle core.
- Each cycle, selects the next fetch address from sequential, branch, jump, call or return sources.
- Owns a small hardware return-address stack, a halt/resume state machine and a stall hold.
- Its pc output feeds instruction memory directly; decode/ALU supply the control inputs.

Parameters:
- PC_W, 6, program counter width in bits; all PC arithmetic is modulo 2^PC_W.
- RESET_VECTOR, 0, pc value loaded on reset.
- STACK_DEPTH, 4, return-stack entries; must be a power of two, 2..16.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold pc and all state this cycle.
- branch_taken  in  1  take PC-relative branch.
- branch_offset  in  PC_W  two's-complement offset, relative to current pc.
- jump  in  1  absolute jump to jump_target.
- call  in  1  push pc+1, then go to jump_target.
- ret  in  1  pop the return stack into pc.
- jump_target  in  PC_W  absolute target for jump and call.
- halt  in  1  enter HALT after this instruction.
- resume  in  1  leave HALT.
- pc  out  PC_W  current fetch address (registered).
- halted  out  1  high while in HALT (registered).
- stack_depth  out  log2(STACK_DEPTH)+1  number of valid stack entries.
- stack_overflow  out  1  sticky; set by a call while the stack is full.
- stack_underflow  out  1  sticky; set by a ret while the stack is empty.

Behaviour:
- Reset (reset_n low, asynchronous): pc=RESET_VECTOR; state=RUN; halted=0; stack_depth=0; both sticky flags=0. Stack contents are don't-care.
- Reset can assert mid-operation (during a stall or HALT) and takes effect immediately.
- All updates occur on the rising clock edge. pc reflects the new value one cycle after the inputs are sampled (single-cycle latency).
- States: RUN and HALT.
- RUN, stall=1: pc, state, stack and flags all hold; every other input is ignored.
- RUN, stall=0: the first matching rule below applies.
  1. halt=1: pc holds, state→HALT, halted=1.
  2. ret=1, depth>0: pc=top of stack; depth decrements.
  3. ret=1, depth=0: pc=pc+1; stack_underflow←1.
  4. call=1, depth<STACK_DEPTH: push pc+1; pc=jump_target; depth increments.
  5. call=1, depth=STACK_DEPTH: pc=jump_target; push is dropped; depth unchanged; stack_overflow←1.
  6. jump=1: pc=jump_target.
  7. branch_taken=1: pc=pc+sign_extend(branch_offset).
  8. Otherwise: pc=pc+1.
- HALT: pc holds; all control inputs except resume are ignored, including stall.
  - resume=1: state→RUN, halted=0, pc=pc+1.
  - halt and resume both asserted in HALT: resume wins.
- Arithmetic: every PC result wraps modulo 2^PC_W. Examples: 63+1=0; 2+(-3)=63. The pushed pc+1 also wraps.
- Simultaneous control inputs are resolved strictly by the priority order above; lower-priority inputs have no side effects (no push, no flag update).
- Sticky flags are cleared only by reset.

Test Plan:
- Reset then 5 free-running cycles → pc sequence 0,1,2,3,4,5; halted=0; stack_depth=0.
- pc=62, no control for 3 cycles → pc 63,0,1. Then branch_taken=1 with offset=6'h3D (-3) at pc=1 → pc=62.
- At pc=10: call with jump_target=40 → pc=40, depth=1. At pc=40: call with target=50 → pc=50, depth=2. Then ret → pc=41. Then ret → pc=11, depth=0. Then ret → pc=12, stack_underflow=1.
- Five nested calls with STACK_DEPTH=4 → fifth call still jumps; depth=4; stack_overflow=1. Four rets return to the addresses pushed by calls 1–4, most recent first.
- At pc=7: stall=1 with jump=1 for 2 cycles → pc stays 7. Drop stall, keep jump=1, jump_target=20 → pc=20. Then call=1 and ret=1 together with depth=0 → ret wins: pc=21, underflow set, no push.
- At pc=30: halt=1 → pc stays 30, halted=1; pc holds for 4 cycles with stall, jump and halt toggling. Assert resume → pc=31, halted=0. Assert reset_n=0 mid-HALT on a later run → pc=0, halted=0 before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle core.
// Picks the next fetch address from sequential, branch, jump, call or
// return sources, keeps a small hardware return-address stack, and runs
// a two-state RUN/HALT machine.
//
// Control inputs have no handshake: they are plain level qualifiers that
// decode/ALU present for the instruction at the current pc. They are
// sampled on every rising edge, and only the highest-priority active one
// has any effect.
//
// The halted output is the registered copy of the FSM state, so a checker
// can observe the state directly through it.
module pc_sequencer #(
  parameter int              PC_W         = 6,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              STACK_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [PC_W-1:0]                branch_offset,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_W-1:0]                jump_target,
  input  logic                           halt,
  input  logic                           resume,
  output logic [PC_W-1:0]                pc,
  output logic                           halted,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);

  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = IDX_W + 1;

  localparam logic [PC_W-1:0]    PC_ONE     = PC_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 halted_q, halted_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  // Return-address storage; contents are meaningless above depth_q.
  logic [PC_W-1:0]      stack_q [STACK_DEPTH];
  logic                 push_en;

  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      pc_branch;
  logic [IDX_W-1:0]     push_idx;
  logic [IDX_W-1:0]     pop_idx;
  logic [PC_W-1:0]      stack_top;
  logic                 stack_empty;
  logic                 stack_full;

  // Address arithmetic and stack pointer decode. Plain PC_W-bit adds wrap
  // modulo 2^PC_W, which is exactly sign-extend-then-truncate for the
  // two's-complement branch offset. Because STACK_DEPTH is a power of two,
  // the low index bits of depth_q are the next free slot, and subtracting
  // one from them gives the top entry (a full stack wraps 0 -> last slot).
  always_comb begin
    pc_inc      = pc_q + PC_ONE;
    pc_branch   = pc_q + branch_offset;
    push_idx    = depth_q[IDX_W-1:0];
    pop_idx     = depth_q[IDX_W-1:0] - IDX_ONE;
    stack_top   = stack_q[pop_idx];
    stack_empty = (depth_q == '0);
    stack_full  = (depth_q == DEPTH_FULL);
  end

  // Next-state decode: stall freezes RUN, HALT only listens to resume, and
  // in RUN the first active control in priority order wins outright.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALT;
          end else if (ret) begin
            if (!stack_empty) begin
              pc_d    = stack_top;
              depth_d = depth_q - DEPTH_ONE;
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end else if (call) begin
            pc_d = jump_target;
            if (!stack_full) begin
              push_en = 1'b1;
              depth_d = depth_q + DEPTH_ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (jump) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = pc_branch;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // FSM, pc, depth and sticky flags with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      halted_q <= 1'b0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stack storage needs no reset: only entries below depth_q are read.
  always_ff @(posedge clock) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc              = pc_q;
  assign halted          = halted_q;
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written reset
// sequences, then randomized stimulus against a queue-based reference model.
module tb_pc_sequencer;

  localparam int PC_W  = 6;
  localparam int SD    = 4;
  localparam int PC_M  = 1 << PC_W;
  localparam int N_RND = 3000;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              stall, branch_taken, jump, call, ret, halt, resume;
  logic [PC_W-1:0]   branch_offset, jump_target;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic [2:0]        stack_depth;
  logic              stack_overflow, stack_underflow;

  always #5 clock = ~clock;

  pc_sequencer #(.PC_W(PC_W), .RESET_VECTOR('0), .STACK_DEPTH(SD)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .call            (call),
    .ret             (ret),
    .jump_target     (jump_target),
    .halt            (halt),
    .resume          (resume),
    .pc              (pc),
    .halted          (halted),
    .stack_depth     (stack_depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  // ---------------- scoreboard counters ----------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_total++;
    if (got !== exp) $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    else n_passed++;
  endtask

  task automatic check_all(input string tag, input int idx, input int e_pc, input int e_h,
                           input int e_d, input int e_o, input int e_u);
    check({tag, ".pc"},     idx, int'(pc),              e_pc);
    check({tag, ".halted"}, idx, int'(halted),          e_h);
    check({tag, ".depth"},  idx, int'(stack_depth),     e_d);
    check({tag, ".ovf"},    idx, int'(stack_overflow),  e_o);
    check({tag, ".unf"},    idx, int'(stack_underflow), e_u);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic br, input logic [5:0] off, input logic j,
                       input logic c, input logic r, input logic [5:0] tgt,
                       input logic h, input logic res);
    stall = s; branch_taken = br; branch_offset = off; jump = j;
    call = c; ret = r; jump_target = tgt; halt = h; resume = res;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 6'd0, 0, 0, 0, 6'd0, 0, 0);
  endtask

  // One clock: inputs already driven; sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s, br, j, c, r, h, res;
    logic [5:0] off, tgt;
    int         e_pc, e_h, e_d, e_o, e_u;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic br, input logic [5:0] off, input logic j,
                     input logic c, input logic r, input logic [5:0] tgt, input logic h,
                     input logic res, input int e_pc, input int e_h, input int e_d,
                     input int e_o, input int e_u);
    vec_t v;
    v.s = s; v.br = br; v.off = off; v.j = j; v.c = c; v.r = r; v.tgt = tgt;
    v.h = h; v.res = res;
    v.e_pc = e_pc; v.e_h = e_h; v.e_d = e_d; v.e_o = e_o; v.e_u = e_u;
    vecs.push_back(v);
  endtask

  task automatic fill_table();
    //   s br off    j c r tgt    h res   pc h d o u
    // free run from reset
    for (int i = 1; i <= 5; i++) add(0,0,6'd0, 0,0,0,6'd0, 0,0, i,0,0,0,0);
    // wrap-around and negative branch
    add(0,0,6'd0,  1,0,0,6'd62, 0,0, 62,0,0,0,0);
    add(0,0,6'd0,  0,0,0,6'd0,  0,0, 63,0,0,0,0);
    add(0,0,6'd0,  0,0,0,6'd0,  0,0,  0,0,0,0,0);
    add(0,0,6'd0,  0,0,0,6'd0,  0,0,  1,0,0,0,0);
    add(0,1,6'h3D, 0,0,0,6'd0,  0,0, 62,0,0,0,0);
    // call / return / underflow
    add(0,0,6'd0,  1,0,0,6'd10, 0,0, 10,0,0,0,0);
    add(0,0,6'd0,  0,1,0,6'd40, 0,0, 40,0,1,0,0);
    add(0,0,6'd0,  0,1,0,6'd50, 0,0, 50,0,2,0,0);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 41,0,1,0,0);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 11,0,0,0,0);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 12,0,0,0,1);
    // five nested calls, overflow, then unwind
    add(0,0,6'd0,  0,1,0,6'd20, 0,0, 20,0,1,0,1);
    add(0,0,6'd0,  0,1,0,6'd30, 0,0, 30,0,2,0,1);
    add(0,0,6'd0,  0,1,0,6'd40, 0,0, 40,0,3,0,1);
    add(0,0,6'd0,  0,1,0,6'd50, 0,0, 50,0,4,0,1);
    add(0,0,6'd0,  0,1,0,6'd60, 0,0, 60,0,4,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 41,0,3,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 31,0,2,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 21,0,1,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 13,0,0,1,1);
    // priority: jump over branch, positive branch, call over jump, ret over call
    add(0,1,6'd5,  1,0,0,6'd25, 0,0, 25,0,0,1,1);
    add(0,1,6'd5,  0,0,0,6'd0,  0,0, 30,0,0,1,1);
    add(0,0,6'd0,  1,1,0,6'd44, 0,0, 44,0,1,1,1);
    add(0,0,6'd0,  0,1,1,6'd9,  0,0, 31,0,0,1,1);
    // pushed return address wraps
    add(0,0,6'd0,  1,0,0,6'd63, 0,0, 63,0,0,1,1);
    add(0,0,6'd0,  0,1,0,6'd5,  0,0,  5,0,1,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0,  0,0,0,1,1);
    // stall holds everything
    add(0,0,6'd0,  1,0,0,6'd7,  0,0,  7,0,0,1,1);
    add(1,0,6'd0,  1,0,0,6'd20, 0,0,  7,0,0,1,1);
    add(1,0,6'd0,  1,0,0,6'd20, 0,0,  7,0,0,1,1);
    add(0,0,6'd0,  1,0,0,6'd20, 0,0, 20,0,0,1,1);
    add(0,0,6'd0,  0,1,1,6'd33, 0,0, 21,0,0,1,1);
    add(0,0,6'd0,  0,0,1,6'd0,  0,0, 22,0,0,1,1);
    add(1,0,6'd0,  0,1,0,6'd50, 0,0, 22,0,0,1,1);
    // halt / resume
    add(0,0,6'd0,  1,0,0,6'd30, 0,0, 30,0,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  1,0, 30,1,0,1,1);
    add(1,0,6'd0,  1,0,0,6'd5,  0,0, 30,1,0,1,1);
    add(0,0,6'd0,  0,1,0,6'd9,  1,0, 30,1,0,1,1);
    add(0,0,6'd0,  1,0,1,6'd2,  0,0, 30,1,0,1,1);
    add(1,0,6'd0,  0,0,0,6'd0,  1,0, 30,1,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  0,1, 31,0,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  1,0, 31,1,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  1,1, 32,0,0,1,1);
    add(1,0,6'd0,  0,0,0,6'd0,  1,0, 32,0,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  1,0, 32,1,0,1,1);
    add(1,0,6'd0,  0,0,0,6'd0,  0,1, 33,0,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  0,1, 34,0,0,1,1);
    add(0,0,6'd0,  0,0,0,6'd0,  1,0, 34,1,0,1,1);
  endtask

  // ---------------- reference model ----------------
  int m_pc;
  bit m_halted, m_ovf, m_unf;
  int m_stack[$];

  function automatic void model_reset();
    m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input bit s, input bit br, input int off, input bit j,
                                     input bit c, input bit r, input int tgt,
                                     input bit h, input bit res);
    int so;
    if (m_halted) begin
      if (res) begin
        m_halted = 0;
        m_pc = (m_pc + 1) % PC_M;
      end
    end else if (!s) begin
      if (h) m_halted = 1;
      else if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = (m_pc + 1) % PC_M; m_unf = 1; end
      end else if (c) begin
        if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % PC_M);
        else m_ovf = 1;
        m_pc = tgt;
      end else if (j) m_pc = tgt;
      else if (br) begin
        so = (off >= PC_M / 2) ? off - PC_M : off;
        m_pc = (m_pc + so + PC_M) % PC_M;
      end else m_pc = (m_pc + 1) % PC_M;
    end
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    idle_inputs();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // directed vector table
    fill_table();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.s, v.br, v.off, v.j, v.c, v.r, v.tgt, v.h, v.res);
      step();
      check_all("vec", i, v.e_pc, v.e_h, v.e_d, v.e_o, v.e_u);
    end

    // asynchronous reset mid-HALT: takes effect before the next edge
    idle_inputs();
    #3 reset_n = 1'b0;
    #1;
    check_all("rst_halt", 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    step();
    check_all("rst_halt", 1, 1, 0, 0, 0, 0);

    // asynchronous reset during a stall after building some stack state
    drive(0, 0, 6'd0, 0, 1, 0, 6'd40, 0, 0);
    step();
    check_all("rst_stall", 0, 40, 0, 1, 0, 0);
    drive(1, 0, 6'd0, 1, 0, 0, 6'd12, 0, 0);
    step();
    check_all("rst_stall", 1, 40, 0, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_all("rst_stall", 2, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    drive(0, 0, 6'd0, 0, 0, 1, 6'd0, 0, 0);
    step();
    check_all("unf_only", 0, 1, 0, 0, 0, 1);

    // randomized stimulus against the reference model
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    #1 reset_n = 1'b1;
    for (int i = 0; i < N_RND; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst", i, m_pc, int'(m_halted), m_stack.size(), int'(m_ovf), int'(m_unf));
        #1 reset_n = 1'b1;
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 6'($urandom_range(0, 63)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            6'($urandom_range(0, 63)), $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
      model_step(stall, branch_taken, int'(branch_offset), jump, call, ret, int'(jump_target),
                 halt, resume);
      step();
      check_all("rnd", i, m_pc, int'(m_halted), m_stack.size(), int'(m_ovf), int'(m_unf));
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
